down_count_ctrl: RTL and testbench
==================================

# down_count_ctrl

Control stage directly upstream of the 4-bit down counter. It loads a start value into the counter, drives the counter's count enable through a programmable prescaler, and watches the counter output `q` for terminal count. It raises `busy` for the run and pulses `done` when `q` reaches zero. Together the two blocks form a start/stop countdown timer.

## Interface
Parameters:
- `CNT_W`, default 4: counter width; matches the down counter's `q`.
- `PRE_W`, default 8: prescaler width. Divide ratio is `prescale`+1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. Low forces the reset state immediately.
- `start` in 1: request a countdown. Sampled only in IDLE.
- `stop` in 1: abort the run. Sampled in LOAD, RUN and DONE.
- `load_val` in `CNT_W`: countdown start value. Captured on the accepted `start`.
- `prescale` in `PRE_W`: enable period minus 1. Captured on the accepted `start`.
- `q` in `CNT_W`: current value from the down counter.
- `cnt_load` out 1: counter synchronous load strobe.
- `cnt_data` out `CNT_W`: load value presented to the counter.
- `cnt_en` out 1: counter decrement enable, one-cycle pulses.
- `busy` out 1: high in LOAD and RUN.
- `done` out 1: one-cycle terminal-count pulse.

## Operation
- State machine has four states:
  - IDLE: waiting for `start`.
  - LOAD: one cycle. `cnt_load`=1 and `cnt_data`=latched value.
  - RUN: prescaled counting.
  - DONE: one cycle. `done`=1.
- State transitions:
  - IDLE→LOAD on `start`=1 and `stop`=0. `load_val` and `prescale` are latched at that edge.
  - If `start` and `stop` are both 1 in IDLE, the block stays in IDLE.
  - LOAD→RUN when the latched value ≠0.
  - LOAD→DONE when the latched value =0. No `cnt_en` is issued.
  - RUN→DONE when `q`==0.
  - DONE→IDLE.
  - `stop`=1 in LOAD or RUN moves to IDLE on the next edge, with no `done`. `stop` has priority over every other transition.
- `start` is ignored outside IDLE.
- Prescaler: `pre_cnt` is cleared on entry to RUN and increments each RUN cycle.
  - `cnt_en` = RUN && `pre_cnt`==`prescale_l` && `q`≠0.
  - `pre_cnt` wraps to 0 on the same edge that `cnt_en` is high.
  - With `prescale`=0, `cnt_en` is high every RUN cycle.
- `cnt_data` holds the latched value in all states. It is 0 after reset.
- `q` is trusted as delivered by the counter. No range check is done on it.

## Timing
- Reset values: `cnt_load`=0, `cnt_data`=0, `cnt_en`=0, `busy`=0, `done`=0. State is IDLE, `pre_cnt`=0, latches are 0.
- Edge numbering: `start` is accepted at edge 0, so cycle 1 is LOAD and RUN begins in cycle 2.
- The counter loads at the end of cycle 1, so `q`=L in the first RUN cycle.
- For L≥1 and prescale P, `done` is high in cycle L·(P+1)+3.
  - Example: L=1, P=0 gives `done` in cycle 4.
- For L=0, `done` is high in cycle 2.
- `cnt_en` pulses are spaced exactly P+1 cycles apart. Exactly L pulses are issued per full run.
- `done` is high for exactly one cycle. `busy` falls in the DONE cycle.
- A reset assertion mid-run drops all outputs to their reset values immediately.

## Configuration
- `DOWN_COUNT_CTRL_AUTO_RELOAD_EN`.
- Defined:
  - DONE→LOAD using the same latched value and prescale, so the block runs repeatedly until `stop`.
  - `busy` stays 1 through DONE.
  - `done` still pulses once per period.
  - `stop` in DONE→IDLE.
- Undefined: DONE→IDLE always, as described above.

## Structure
- Package `down_count_pkg` holds:
  - state enum `dcc_state_t` (IDLE, LOAD, RUN, DONE);
  - default widths `DCC_CNT_W`=4 and `DCC_PRE_W`=8.
- One natural sub-module, `dcc_prescaler`:
  - inputs: clear, run, `prescale_l`;
  - output: tick;
  - `cnt_en` = tick && `q`≠0.

## Test plan
- Reset → all outputs 0. Assert reset mid-RUN → outputs return to 0 immediately and the state is IDLE.
- `load_val`=3, `prescale`=0, `start` at edge 0 → `cnt_load` in cycle 1; `cnt_en` in cycles 2, 3, 4; `done` in cycle 6.
- `load_val`=2, `prescale`=3 → 2 `cnt_en` pulses 4 cycles apart; `done` in cycle 11.
- `load_val`=0 → `done` in cycle 2; no `cnt_en`.
- `stop` during RUN → IDLE next cycle, no `done`. `start`+`stop` together in IDLE → stays IDLE. `start` during RUN is ignored.
- With `DOWN_COUNT_CTRL_AUTO_RELOAD_EN`, `load_val`=1, `prescale`=0 → `done` every 4 cycles, `busy` held high, `stop` returns to IDLE.

Source files
------------

// File: rtl/down_count_pkg.sv
// ---------------------------------------------------------------------------
// down_count_pkg: shared state encoding and default widths for down_count_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package down_count_pkg;

  localparam int DCC_CNT_W = 4;
  localparam int DCC_PRE_W = 8;

  typedef enum logic [1:0] {
    DCC_IDLE = 2'd0,
    DCC_LOAD = 2'd1,
    DCC_RUN  = 2'd2,
    DCC_DONE = 2'd3
  } dcc_state_t;

endpackage

`default_nettype wire

// File: rtl/down_count_ctrl_prescaler.sv
// ---------------------------------------------------------------------------
// dcc_prescaler: divide-by-(prescale_l+1) tick generator, active only in RUN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcc_prescaler
  import down_count_pkg::*;
#(
  parameter int PRE_W = DCC_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [PRE_W-1:0] prescale_l_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  assign tick_o = run_i && (pre_cnt_q == prescale_l_i);

  // Wrap on the tick edge so ticks are spaced exactly prescale_l+1 cycles.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear_i) begin
      pre_cnt_d = '0;
    end else if (run_i) begin
      pre_cnt_d = tick_o ? '0 : pre_cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/down_count_ctrl.sv
// ---------------------------------------------------------------------------
// down_count_ctrl: start/stop countdown controller driving a 4-bit down counter.
// Define DOWN_COUNT_CTRL_AUTO_RELOAD_EN to repeat runs until stop. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module down_count_ctrl
  import down_count_pkg::*;
#(
  parameter int CNT_W = DCC_CNT_W,
  parameter int PRE_W = DCC_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [PRE_W-1:0] prescale_i,
  input  logic [CNT_W-1:0] q_i,
  output logic             cnt_load_o,
  output logic [CNT_W-1:0] cnt_data_o,
  output logic             cnt_en_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [1:0] S_IDLE = DCC_IDLE;
  localparam logic [1:0] S_LOAD = DCC_LOAD;
  localparam logic [1:0] S_RUN  = DCC_RUN;
  localparam logic [1:0] S_DONE = DCC_DONE;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] load_q;
  logic [CNT_W-1:0] load_d;
  logic [PRE_W-1:0] prescale_q;
  logic [PRE_W-1:0] prescale_d;
  logic             tick;

  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    prescale_d = prescale_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          state_d    = S_LOAD;
          load_d     = load_val_i;
          prescale_d = prescale_i;
        end
      end
      S_LOAD: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (load_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (q_i == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
`ifdef DOWN_COUNT_CTRL_AUTO_RELOAD_EN
        state_d = stop_i ? S_IDLE : S_LOAD;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      load_q     <= '0;
      prescale_q <= '0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      prescale_q <= prescale_d;
    end
  end

  // Counter is cleared in LOAD so the first RUN cycle starts from zero.
  dcc_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (state_q == S_LOAD),
    .run_i        (state_q == S_RUN),
    .prescale_l_i (prescale_q),
    .tick_o       (tick)
  );

  assign cnt_load_o = (state_q == S_LOAD);
  assign cnt_data_o = load_q;
  assign cnt_en_o   = tick && (q_i != '0);
  assign done_o     = (state_q == S_DONE);
`ifdef DOWN_COUNT_CTRL_AUTO_RELOAD_EN
  assign busy_o     = (state_q != S_IDLE);
`else
  assign busy_o     = (state_q == S_LOAD) || (state_q == S_RUN);
`endif

endmodule

`default_nettype wire

// File: tb/tb_down_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_down_count_ctrl: randomized scoreboard bench for down_count_ctrl with a
// behavioural down-counter model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_down_count_ctrl;
  import down_count_pkg::*;

  localparam int CW = 4;
  localparam int PW = 8;
`ifdef DOWN_COUNT_CTRL_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int K_LOAD = 0;
  localparam int K_EN   = 1;
  localparam int K_DONE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] load_val = '0;
  logic [PW-1:0] prescale = '0;
  logic [CW-1:0] q;
  logic          cnt_load;
  logic [CW-1:0] cnt_data;
  logic          cnt_en;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int busy_lo = 1;
  int busy_hi = 0;

  typedef struct {
    int cyc;
    int kind;
    int data;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  down_count_ctrl #(
    .CNT_W (CW),
    .PRE_W (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .stop_i     (stop),
    .load_val_i (load_val),
    .prescale_i (prescale),
    .q_i        (q),
    .cnt_load_o (cnt_load),
    .cnt_data_o (cnt_data),
    .cnt_en_o   (cnt_en),
    .busy_o     (busy),
    .done_o     (done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream 4-bit down counter
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 q <= '0;
    else if (cnt_load)          q <= cnt_data;
    else if (cnt_en && q != '0) q <= q - 1'b1;
  end

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Cycles from accepted start to the done pulse
  function automatic int dur(int L, int P);
    return (L == 0) ? 2 : L * (P + 1) + 3;
  endfunction

  function automatic void push(int c, int rel, int kind, int data, int endc);
    ev_t e;
    if (rel <= endc) begin
      e.cyc = c + rel; e.kind = kind; e.data = data;
      exp_q.push_back(e);
    end
  endfunction

  // Reference model: load in cycle 1, L enables spaced P+1 apart starting at
  // cycle 2+P, done at dur(); in auto mode the pattern repeats every dur().
  function automatic void plan(int c, int L, int P, int endc);
    int D;
    int base;
    D = dur(L, P);
    base = 0;
    do begin
      push(c, base + 1, K_LOAD, L, endc);
      for (int k = 0; k < L; k++) push(c, base + 2 + P + k * (P + 1), K_EN, 0, endc);
      push(c, base + D, K_DONE, 0, endc);
      base += D;
    end while (AUTO && base < endc);
  endfunction

  always @(negedge clk) begin
    int kind;
    ev_t e;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missing event", -1, e.kind);
      end
      chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      if (cnt_load || cnt_en || done) begin
        if (int'(cnt_load) + int'(cnt_en) + int'(done) > 1) kind = 9;
        else if (cnt_load) kind = K_LOAD;
        else if (cnt_en)   kind = K_EN;
        else               kind = K_DONE;
        if (exp_q.size() == 0) begin
          chk("unexpected event", kind, -1);
        end else begin
          e = exp_q.pop_front();
          chk("event kind", kind, e.kind);
          chk("event cycle", cyc, e.cyc);
          if (kind == K_LOAD) chk("cnt_data", int'(cnt_data), e.data);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // s = cycle in which stop is asserted (0: none); ign pulses start in cycle 2
  task automatic run_txn(int L, int P, int s_in, bit ign);
    int D;
    int s;
    int endc;
    int c;
    D = dur(L, P);
    s = s_in;
    if (AUTO && s == 0) s = D;
    endc = (s > 0) ? s : D;
    c = cyc;
    plan(c, L, P, endc);
    busy_lo = c + 1;
    busy_hi = c + ((s > 0) ? s : D - 1);
    start = 1'b1; stop = 1'b0;
    load_val = CW'(L); prescale = PW'(P);
    step(1);
    start = 1'b0;
    load_val = CW'($urandom); prescale = PW'($urandom);
    for (int k = 1; k <= endc; k++) begin
      start = ign && (k == 2);
      stop  = (s > 0) && (k == s);
      if (start) load_val = CW'($urandom);
      step(1);
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic start_stop();
    start = 1'b1; stop = 1'b1; load_val = CW'($urandom_range(1, 15));
    step(1);
    start = 1'b0; stop = 1'b0;
    step(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int L;
    int P;
    int D;
    int s;
    bit ign;

    #2;
    chk("reset cnt_load", int'(cnt_load), 0);
    chk("reset cnt_data", int'(cnt_data), 0);
    chk("reset cnt_en", int'(cnt_en), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset state", int'(dut.state_q), int'(DCC_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);
    mon_en = 1'b1;

    run_txn(3, 0, 0, 1'b0); step(2);
    run_txn(2, 3, 0, 1'b0); step(1);
    run_txn(0, 0, 0, 1'b0); step(1);
    run_txn(4, 1, 5, 1'b0); step(1);
    run_txn(5, 0, 0, 1'b1); step(1);
    start_stop();
`ifdef DOWN_COUNT_CTRL_AUTO_RELOAD_EN
    run_txn(1, 0, 14, 1'b0); step(1);
`endif

    for (int i = 0; i < 30; i++) begin
      L = $urandom_range(0, 15);
      P = $urandom_range(0, 4);
      D = dur(L, P);
      s = 0;
      if ($urandom_range(0, 9) == 0) begin
        start_stop();
      end else begin
        if (AUTO) s = $urandom_range(1, 3 * D);
        else if ($urandom_range(0, 2) == 0) s = $urandom_range(1, D - 1);
        ign = (L > 0) && (s == 0 || s >= 2) && ($urandom_range(0, 1) == 1);
        run_txn(L, P, s, ign);
        step($urandom_range(0, 3));
      end
    end
    step(3);
    chk("scoreboard drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of a run
    mon_en = 1'b0;
    start = 1'b1; load_val = 4'd5; prescale = 8'd2;
    step(1);
    start = 1'b0;
    step(5);
    chk("busy before reset", int'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrun cnt_load", int'(cnt_load), 0);
    chk("midrun cnt_data", int'(cnt_data), 0);
    chk("midrun cnt_en", int'(cnt_en), 0);
    chk("midrun busy", int'(busy), 0);
    chk("midrun done", int'(done), 0);
    chk("midrun state", int'(dut.state_q), int'(DCC_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
